// File: rtl/noc_pckt_tx.sv
// noc_pckt_tx: packet transmit stage between a local resource and a NoC switch.
// Packets {col,row,data} are staged in a small FIFO and written into the
// switch input FIFO whenever it is not full. An overflow report from the
// switch halts the block until reset and sets a sticky error flag.
//
// Optional feature macro: TX_STATS_EN (enables the delivered-packet counter).
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   src_valid_i / src_ready_o      resource handshake
//   src_col_i, src_row_i, src_data_i  packet fields
//   wr_en_o, pckt_o                write strobe and packet to switch FIFO
//   nxt_fifo_full_i                switch FIFO full (backpressure)
//   nxt_fifo_overflow_i            switch FIFO overflow report
//   err_o                          sticky overflow error
//   sent_cnt_o                     delivered packet count (0 without TX_STATS_EN)
module noc_pckt_tx #(
  parameter int PCKT_COL_ADDR_W = 4,
  parameter int PCKT_ROW_ADDR_W = 4,
  parameter int PCKT_DATA_W     = 8,
  parameter int PCKT_W          = PCKT_COL_ADDR_W + PCKT_ROW_ADDR_W + PCKT_DATA_W,
  parameter int TX_FIFO_DEPTH_W = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       src_valid_i,
  output logic                       src_ready_o,
  input  logic [PCKT_COL_ADDR_W-1:0] src_col_i,
  input  logic [PCKT_ROW_ADDR_W-1:0] src_row_i,
  input  logic [PCKT_DATA_W-1:0]     src_data_i,
  output logic                       wr_en_o,
  output logic [PCKT_W-1:0]          pckt_o,
  input  logic                       nxt_fifo_full_i,
  input  logic                       nxt_fifo_overflow_i,
  output logic                       err_o,
  output logic [15:0]                sent_cnt_o
);

  localparam int unsigned DEPTH = 2 ** TX_FIFO_DEPTH_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [PCKT_W-1:0]          mem_q [DEPTH];
  logic [TX_FIFO_DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [TX_FIFO_DEPTH_W:0]   occ_q, occ_d;
  logic                       err_q;
  logic                       live_q;
  logic                       fifo_full, fifo_empty;
  logic                       push, pop;

  assign fifo_full  = (occ_q == (TX_FIFO_DEPTH_W+1)'(DEPTH));
  assign fifo_empty = (occ_q == '0);

  // live_q keeps src_ready_o low while reset is held and raises it on the
  // first edge after release (the FIFO alone would read as not-full).
  assign src_ready_o = live_q && !fifo_full && (state_q != HALT);
  assign wr_en_o     = !fifo_empty && !nxt_fifo_full_i && (state_q != HALT);
  assign pckt_o      = mem_q[rd_ptr_q];
  assign err_o       = err_q;

  assign push = src_valid_i && src_ready_o;
  assign pop  = wr_en_o;

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + (TX_FIFO_DEPTH_W+1)'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - (TX_FIFO_DEPTH_W+1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == HALT) || nxt_fifo_overflow_i) begin
      state_d = HALT;
    end else if (occ_d == '0) begin
      state_d = IDLE;
    end else if (nxt_fifo_full_i) begin
      state_d = STALL;
    end else begin
      state_d = SEND;
    end
  end

  // FSM with registered error flag and FIFO bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      live_q  <= 1'b1;
      state_q <= state_d;
      if (nxt_fifo_overflow_i) begin
        err_q <= 1'b1;
      end
      occ_q <= occ_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + TX_FIFO_DEPTH_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + TX_FIFO_DEPTH_W'(1);
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {src_col_i, src_row_i, src_data_i};
    end
  end

`ifdef TX_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (wr_en_o && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign sent_cnt_o = cnt_q;
`else
  assign sent_cnt_o = '0;
`endif

endmodule

// File: doc/noc_pckt_tx.md
NOC_PCKT_TX -- requirements
Module: noc_pckt_tx

Interface
REQ-001 SHALL have parameter PCKT_COL_ADDR_W, default 4: destination column field width.
REQ-002 SHALL have parameter PCKT_ROW_ADDR_W, default 4: destination row field width.
REQ-003 SHALL have parameter PCKT_DATA_W, default 8: payload width.
REQ-004 SHALL have parameter PCKT_W, default PCKT_COL_ADDR_W+PCKT_ROW_ADDR_W+PCKT_DATA_W: packet width.
REQ-005 SHALL have parameter TX_FIFO_DEPTH_W, default 2: staging FIFO depth is 2**TX_FIFO_DEPTH_W.
REQ-006 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port src_valid_i, input, 1: resource offers a packet.
REQ-009 SHALL have port src_ready_o, output, 1: block accepts a packet this cycle.
REQ-010 SHALL have port src_col_i, input, PCKT_COL_ADDR_W: destination column.
REQ-011 SHALL have port src_row_i, input, PCKT_ROW_ADDR_W: destination row.
REQ-012 SHALL have port src_data_i, input, PCKT_DATA_W: payload.
REQ-013 SHALL have port wr_en_o, output, 1: write strobe into the switch input FIFO.
REQ-014 SHALL have port pckt_o, output, PCKT_W: packet presented to the switch.
REQ-015 SHALL have port nxt_fifo_full_i, input, 1: switch input FIFO full.
REQ-016 SHALL have port nxt_fifo_overflow_i, input, 1: switch input FIFO overflowed.
REQ-017 SHALL have port err_o, output, 1: sticky overflow error.
REQ-018 SHALL have port sent_cnt_o, output, 16: packets delivered (see Configuration).

Function
REQ-019 SHALL format packets as pckt_o = {col, row, data}: col in MSBs, data in LSBs.
REQ-020 SHALL accept a packet into the staging FIFO on a cycle with src_valid_i && src_ready_o.
REQ-021 SHALL drive src_ready_o = !fifo_full && state != HALT.
REQ-022 SHALL drive pckt_o combinationally from the FIFO head and wr_en_o = !fifo_empty && !nxt_fifo_full_i && state != HALT.
REQ-023 SHALL pop the FIFO head on every cycle with wr_en_o high.
REQ-024 SHALL have no bypass path: a packet accepted into an empty FIFO in cycle N is first visible on wr_en_o in cycle N+1.
REQ-025 SHALL perform push and pop in the same cycle with the occupancy unchanged; pointers wrap modulo depth.
REQ-026 SHALL hold the FIFO head and pckt_o stable while nxt_fifo_full_i is high.
REQ-027 SHALL implement FSM states IDLE (FIFO empty), SEND (non-empty and !nxt_fifo_full_i), STALL (non-empty and nxt_fifo_full_i), and HALT, with state re-evaluated each cycle from the next occupancy and nxt_fifo_full_i.
REQ-028 SHALL enter HALT from any state when nxt_fifo_overflow_i is sampled high, and SHALL set err_o in the same transition.
REQ-029 SHALL leave HALT only through reset; while in HALT, wr_en_o and src_ready_o SHALL be 0 and FIFO contents SHALL be frozen.

Reset
REQ-030 SHALL asynchronously clear on rst_ni low: FIFO pointers and occupancy to 0, state to IDLE, err_o to 0, sent_cnt_o to 0.
REQ-031 SHALL drop any in-flight FIFO contents on reset asserted mid-operation and hold wr_en_o=0 and src_ready_o=0 while rst_ni is low.
REQ-032 SHALL raise src_ready_o on the first clock edge after rst_ni deasserts.

Configuration
REQ-033 SHALL, with TX_STATS_EN defined, increment sent_cnt_o by 1 on each wr_en_o cycle, saturating at 16'hFFFF.
REQ-034 SHALL, without TX_STATS_EN, tie sent_cnt_o to 16'h0 and keep the port present.

Verification
REQ-035 SHALL cover: defaults, push col=3 row=5 data=8'hA7 at cycle N -> wr_en_o=1 with pckt_o=16'h35A7 at cycle N+1, exactly one cycle.
REQ-036 SHALL cover: nxt_fifo_full_i=1, push 4 packets -> src_ready_o=0 after the 4th push, wr_en_o=0; release full -> 4 packets emitted in order on 4 consecutive cycles.
REQ-037 SHALL cover: continuous src_valid_i with full low -> one packet per cycle with occupancy steady at 1 and no stall.
REQ-038 SHALL cover: nxt_fifo_overflow_i pulsed for 1 cycle with 2 queued -> err_o=1, wr_en_o=0 and src_ready_o=0 persist until reset.
REQ-039 SHALL cover: rst_ni low for 1 cycle with 3 queued -> wr_en_o=0 after reset, FIFO empty, err_o=0.
REQ-040 SHALL cover: TX_STATS_EN defined, 10 packets sent -> sent_cnt_o=10; TX_STATS_EN undefined -> sent_cnt_o=0.
